contador_multicanal: RTL and testbench
======================================

// Module: contador_multicanal
// PURPOSE
//  Parametrised successor of the single-channel word counter: NUM_CH independent
//  event counters of COUNT_W bits, fed by one valid strobe per channel.
//  Selectable wrap or saturate mode, sticky per-channel overflow flags, global clear.
//  Registered req/idx read port returns one channel's count.
//  Sits beside the FIFO/arbiter datapath and counts words popped per lane.
// PARAMETERS
//  NUM_CH   4  number of channels, 1..16
//  COUNT_W  5  counter width per channel, 2..16
//  IDX_W    2  read-index width, >= clog2(NUM_CH)
//  SATURATE 0  0: counter wraps max->0; 1: counter holds at max
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         asynchronous, active-low; 0 = reset asserted
//  enable      in   1         request counting; sampled by the FSM
//  valid_in    in   NUM_CH    bit c = one event on channel c this cycle
//  clear       in   1         synchronous clear of all counters and flags
//  req         in   1         read request, single-cycle pulse
//  idx         in   IDX_W     channel to read; sampled with req
//  count       out  COUNT_W   read data, registered
//  count_valid out  1         high 1 cycle when count is valid
//  overflow    out  NUM_CH    sticky: channel c wrapped or hit saturation
//  active      out  1         FSM in ACTIVE state
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all counters=0;
//   count=0, count_valid=0, overflow=0, active=0.
//  FSM (registered) has two states:
//   IDLE->ACTIVE when enable=1; ACTIVE->IDLE when enable=0.
//   Counting starts/stops 1 cycle after the enable change.
//  Increment:
//   In ACTIVE, at each edge, counter[c] += 1 for each c with valid_in[c]=1.
//   All channels may increment in the same cycle.
//   In IDLE, valid_in is ignored and counts hold.
//  Top value:
//   SATURATE=0: counter at 2^COUNT_W-1 plus an event -> 0, overflow[c] <= 1.
//   SATURATE=1: counter stays at 2^COUNT_W-1; overflow[c] <= 1 on first
//    event attempted at max.
//  overflow bits are cleared only by clear or reset.
//  clear=1 at edge (either state):
//   All counters=0 and overflow=0; clear beats a same-cycle increment.
//   FSM state is unaffected.
//  Read, 1-cycle latency:
//   req=1 at edge n -> count_valid=1 during cycle n+1.
//   count = counter[idx] value after edge n, i.e. including the cycle-n increment
//    and reading 0 if clear=1 in cycle n.
//   count holds its last value when count_valid=0.
//   Back-to-back reqs are legal, one result per cycle.
//   idx >= NUM_CH: count=0, count_valid=1.
//  Reset mid-operation: immediate return to reset values.
//   An outstanding read is dropped (no count_valid).
// TESTING
//  T1 reset=0 with random inputs -> all outputs 0, active=0;
//   release reset, enable=0, valid_in=4'hF for 5 cycles -> every count reads 0.
//  T2 enable=1, then 1 idle cycle, then valid_in[1]=1 for 7 cycles;
//   req idx=1 -> count=7 in the next cycle, count_valid=1 for exactly 1 cycle.
//  T3 SATURATE=0, COUNT_W=5, ch0 sees 33 events -> read 1, overflow=4'b0001;
//   SATURATE=1, same stimulus -> read 31, overflow[0]=1.
//  T4 valid_in=4'hF together with clear=1 and req idx=2 -> count=0;
//   next cycle all counters=0 and overflow=0.
//  T5 reqs on idx 0,1,2,3 in consecutive cycles while counting
//   -> 4 consecutive count_valid cycles, each value matching the bench model.
//  T6 req at edge n, reset=0 mid-cycle n -> no count_valid;
//   all state 0 after reset release.

Source files
------------

// File: rtl/contador_multicanal.sv
// Multi-channel event counter: NUM_CH independent counters with wrap or saturate,
// sticky overflow flags, global clear and a registered single-channel read port.
module contador_multicanal #(
    parameter int NUM_CH   = 4,
    parameter int COUNT_W  = 5,
    parameter int IDX_W    = 2,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_CH-1:0]  valid_in,
    input  logic               clear,
    input  logic               req,
    input  logic [IDX_W-1:0]   idx,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    output logic [NUM_CH-1:0]  overflow,
    output logic               active
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_next;
    logic [COUNT_W-1:0] cnt_q [NUM_CH];
    logic [COUNT_W-1:0] cnt_d [NUM_CH];
    logic [NUM_CH-1:0]  ovf_d;
    logic [COUNT_W-1:0] rd_data;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = ACTIVE;
            ACTIVE:  if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign active = (state == ACTIVE);

    // Clear has priority over a same-cycle increment; counting only in ACTIVE.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            ovf_d[c] = overflow[c];
            if (clear) begin
                cnt_d[c] = '0;
                ovf_d[c] = 1'b0;
            end else if (state == ACTIVE && valid_in[c]) begin
                if (cnt_q[c] == CNT_MAX) begin
                    ovf_d[c] = 1'b1;
                    cnt_d[c] = (SATURATE != 0) ? CNT_MAX : '0;
                end else begin
                    cnt_d[c] = cnt_q[c] + COUNT_W'(1);
                end
            end
        end
    end

    // Read data is the post-edge value, so it sees this cycle's increment or clear.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (idx == IDX_W'(c)) rd_data = cnt_d[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            overflow    <= '0;
            count       <= '0;
            count_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
        end else begin
            state       <= state_next;
            overflow    <= ovf_d;
            count_valid <= req;
            if (req) count <= rd_data;
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
        end
    end

endmodule

// File: tb/tb_contador_multicanal.sv
// Self-checking bench: wrap and saturate instances share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_contador_multicanal;

    localparam int NUM_CH  = 4;
    localparam int COUNT_W = 5;
    localparam int IDX_W   = 2;
    localparam int CMAX    = (1 << COUNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NUM_CH-1:0] valid_in;
    logic              clear;
    logic              req;
    logic [IDX_W-1:0]  idx;

    logic [COUNT_W-1:0] count_w, count_s;
    logic               count_valid_w, count_valid_s;
    logic [NUM_CH-1:0]  overflow_w, overflow_s;
    logic               active_w, active_s;

    int n_cmp = 0;
    int n_err = 0;

    int m_cnt [2][NUM_CH];
    bit m_ovf [2][NUM_CH];
    bit m_active;
    bit exp_valid;
    int exp_count [2];

    always #5 clk = ~clk;

    contador_multicanal #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .IDX_W(IDX_W), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .valid_in(valid_in), .clear(clear),
        .req(req), .idx(idx), .count(count_w), .count_valid(count_valid_w),
        .overflow(overflow_w), .active(active_w)
    );

    contador_multicanal #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .IDX_W(IDX_W), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .valid_in(valid_in), .clear(clear),
        .req(req), .idx(idx), .count(count_s), .count_valid(count_valid_s),
        .overflow(overflow_s), .active(active_s)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [NUM_CH-1:0] model_ovf(input int d);
        logic [NUM_CH-1:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_ovf[d][c];
        return v;
    endfunction

    task automatic model_zero();
        for (int d = 0; d < 2; d++) begin
            exp_count[d] = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[d][c] = 0;
                m_ovf[d][c] = 1'b0;
            end
        end
        m_active  = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic check_output();
        check("active_w", active_w, m_active);
        check("active_s", active_s, m_active);
        check("count_valid_w", count_valid_w, exp_valid);
        check("count_valid_s", count_valid_s, exp_valid);
        check("count_w", count_w, exp_count[0]);
        check("count_s", count_s, exp_count[1]);
        check("overflow_w", overflow_w, model_ovf(0));
        check("overflow_s", overflow_s, model_ovf(1));
    endtask

    // One clock edge: advance the reference model from the pre-edge inputs, then check.
    task automatic apply_stimulus();
        @(posedge clk);
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (clear) begin
                        m_cnt[d][c] = 0;
                        m_ovf[d][c] = 1'b0;
                    end else if (m_active && valid_in[c]) begin
                        if (d == 0) begin
                            if (m_cnt[d][c] + 1 > CMAX) m_ovf[d][c] = 1'b1;
                            m_cnt[d][c] = (m_cnt[d][c] + 1) % (CMAX + 1);
                        end else begin
                            if (m_cnt[d][c] == CMAX) m_ovf[d][c] = 1'b1;
                            else m_cnt[d][c] = m_cnt[d][c] + 1;
                        end
                    end
                end
                if (req) exp_count[d] = (int'(idx) < NUM_CH) ? m_cnt[d][idx] : 0;
            end
            m_active  = enable;
            exp_valid = req;
        end
        #1;
        check_output();
    endtask

    task automatic set_inputs(input logic en, input logic [NUM_CH-1:0] v, input logic clr,
                              input logic rq, input logic [IDX_W-1:0] ix);
        enable = en; valid_in = v; clear = clr; req = rq; idx = ix;
    endtask

    initial begin
        set_inputs(1'b0, '0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        model_zero();

        // T1: reset held with random inputs, then idle counting is ignored
        #1;
        check_output();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
            apply_stimulus();
        end
        @(posedge clk); #1;
        reset = 1'b1;
        set_inputs(1'b0, 4'hF, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) apply_stimulus();
        for (int i = 0; i < NUM_CH; i++) begin
            set_inputs(1'b0, 4'hF, 1'b0, 1'b1, 2'(i));
            apply_stimulus();
            check("t1_idle_read", count_w, 0);
        end

        // T2: enable, one idle cycle, seven events on channel 1
        set_inputs(1'b1, '0, 1'b0, 1'b0, '0);
        apply_stimulus();
        apply_stimulus();
        set_inputs(1'b1, 4'b0010, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) apply_stimulus();
        set_inputs(1'b1, '0, 1'b0, 1'b1, 2'd1);
        apply_stimulus();
        check("t2_count", count_w, 7);
        check("t2_valid", count_valid_w, 1);
        set_inputs(1'b1, '0, 1'b0, 1'b0, 2'd1);
        apply_stimulus();
        check("t2_valid_drop", count_valid_w, 0);

        // T3: 33 events on channel 0, wrap versus saturate
        @(negedge clk);
        reset = 1'b0;
        model_zero();
        @(posedge clk); #1;
        reset = 1'b1;
        set_inputs(1'b1, '0, 1'b0, 1'b0, '0);
        apply_stimulus();
        set_inputs(1'b1, 4'b0001, 1'b0, 1'b0, '0);
        for (int i = 0; i < 33; i++) apply_stimulus();
        set_inputs(1'b1, '0, 1'b0, 1'b1, 2'd0);
        apply_stimulus();
        check("t3_wrap_count", count_w, 1);
        check("t3_wrap_ovf", overflow_w, 4'b0001);
        check("t3_sat_count", count_s, CMAX);
        check("t3_sat_ovf0", overflow_s[0], 1);

        // T4: clear beats a same-cycle increment and read
        set_inputs(1'b1, 4'hF, 1'b1, 1'b1, 2'd2);
        apply_stimulus();
        check("t4_count_w", count_w, 0);
        check("t4_count_s", count_s, 0);
        set_inputs(1'b1, '0, 1'b0, 1'b0, '0);
        apply_stimulus();
        check("t4_ovf_w", overflow_w, 0);
        check("t4_ovf_s", overflow_s, 0);

        // T5: back-to-back reads while counting
        for (int i = 0; i < NUM_CH; i++) begin
            set_inputs(1'b1, 4'($urandom), 1'b0, 1'b1, 2'(i));
            apply_stimulus();
            check("t5_valid", count_valid_w, 1);
        end
        set_inputs(1'b1, '0, 1'b0, 1'b0, '0);
        apply_stimulus();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            set_inputs($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 19) == 0,
                       1'($urandom), 2'($urandom));
            apply_stimulus();
        end

        // T6: reset asserted mid-cycle with a read pending
        set_inputs(1'b1, 4'hF, 1'b0, 1'b1, 2'd1);
        #3;
        reset = 1'b0;
        model_zero();
        #1;
        check_output();
        @(posedge clk); #1;
        check("t6_no_valid", count_valid_w, 0);
        check_output();
        reset = 1'b1;
        set_inputs(1'b0, '0, 1'b0, 1'b0, '0);
        apply_stimulus();
        for (int i = 0; i < NUM_CH; i++) begin
            set_inputs(1'b0, '0, 1'b0, 1'b1, 2'(i));
            apply_stimulus();
            check("t6_zero_w", count_w, 0);
            check("t6_zero_s", count_s, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
